// File: rtl/mux_arb.sv
// mux_arb: registered N:1 channel mux with select-driven or round-robin grant.
module mux_arb #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int MODE     = 0,
  parameter int SW       = $clog2(CHANNELS)
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SW-1:0]             sel,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SW-1:0]             out_chan
);
  logic [SW-1:0] rr_ptr, grant;
  logic found, can_load, xfer;
  always_comb begin
    int idx;
    idx = 0;
    grant = '0;
    found = 1'b0;
    if (MODE == 1) begin
      for (int k = 0; k < CHANNELS; k++) begin
        idx = int'(rr_ptr) + k;
        idx = idx >= CHANNELS ? idx - CHANNELS : idx;
        if (!found && in_valid[idx]) begin
          found = 1'b1;
          grant = SW'(idx);
        end
      end
    end else begin
      found = int'(sel) < CHANNELS;
      grant = sel;
    end
  end
  assign can_load = !out_valid || out_ready;
  // reset gates the grant so nothing can be accepted while it is held
  assign in_ready = (found && can_load && !rst) ? CHANNELS'(1) << grant : '0;
  assign xfer = |(in_valid & in_ready);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[grant*WIDTH +: WIDTH];
      out_chan  <= grant;
      if (MODE == 1) rr_ptr <= (int'(grant) == CHANNELS - 1) ? '0 : grant + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule
